// File: rtl/ltc2387_decimator.sv
// ltc2387_decimator
// Boxcar decimator for the LTC2387-18 capture path. Each block of 2^eff_log2
// valid samples is summed, and the floored mean is pushed into a small
// first-word-fall-through FIFO. The FIFO feeds a valid/ready stream. A sticky
// overflow flag records any result that was dropped because the FIFO was full.
module ltc2387_decimator #(
    parameter int ADC_WIDTH    = 18,
    parameter int DEC_LOG2_MAX = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              sys_clk_int,
    input  logic                              reset_n_int,
    input  logic                              enable,
    input  logic [3:0]                        dec_log2,
    input  logic [ADC_WIDTH-1:0]              adc_data_in,
    input  logic                              adc_valid_in,
    output logic [ADC_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    input  logic                              overflow_clr
);

    localparam int ACC_W = ADC_WIDTH + DEC_LOG2_MAX;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               eff_log2_q, eff_log2_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DEC_LOG2_MAX-1:0]  cnt_q, cnt_d;
    logic                     push_q, push_d;
    logic [ADC_WIDTH-1:0]     push_data_q, push_data_d;

    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic [ADC_WIDTH-1:0]     mem [FIFO_DEPTH];

    // Datapath helpers
    logic [3:0]               dec_clamped;
    logic [DEC_LOG2_MAX:0]    block_len_m1;
    logic                     block_last;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_shift;
    logic                     fifo_full;
    logic                     pop;
    logic                     push_ok;

    // Clamp the requested ratio and derive the block-complete condition.
    always_comb begin
        dec_clamped  = (dec_log2 > 4'(DEC_LOG2_MAX)) ? 4'(DEC_LOG2_MAX) : dec_log2;
        block_len_m1 = ((DEC_LOG2_MAX + 1)'(1) << eff_log2_q) - (DEC_LOG2_MAX + 1)'(1);
        block_last   = (cnt_q == block_len_m1[DEC_LOG2_MAX-1:0]);
        sample_ext   = {{DEC_LOG2_MAX{adc_data_in[ADC_WIDTH-1]}}, adc_data_in};
        sum          = acc_q + sample_ext;
        // Arithmetic shift floors toward -inf; the mean always fits ADC_WIDTH.
        sum_shift    = sum >>> eff_log2_q;
    end

    // Next-state logic: idle/accumulate control, block completion and result staging.
    always_comb begin
        state_d     = state_q;
        eff_log2_d  = eff_log2_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = ACCUM;
                    eff_log2_d = dec_clamped;
                    acc_d      = '0;
                    cnt_d      = '0;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    // Partial block is thrown away; nothing is pushed.
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (adc_valid_in) begin
                    if (block_last) begin
                        push_d      = 1'b1;
                        push_data_d = sum_shift[ADC_WIDTH-1:0];
                        acc_d       = '0;
                        cnt_d       = '0;
                        // New ratio only takes effect on a block boundary.
                        eff_log2_d  = dec_clamped;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + DEC_LOG2_MAX'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge sys_clk_int or negedge reset_n_int) begin
        if (!reset_n_int) begin
            state_q     <= IDLE;
            eff_log2_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            eff_log2_q  <= eff_log2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // FIFO bookkeeping: a push into a full FIFO is accepted only if a pop frees a slot.
    always_comb begin
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        pop        = (level_q != '0) && out_ready;
        push_ok    = push_q && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LVL_W'(1);
        end
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        // Setting wins over a simultaneous clear.
        if (push_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers, fill level and sticky overflow.
    always_ff @(posedge sys_clk_int or negedge reset_n_int) begin
        if (!reset_n_int) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because the level gates visibility.
    always_ff @(posedge sys_clk_int) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    // First-word-fall-through output, forced to zero whenever the FIFO is empty.
    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = out_valid ? mem[rd_ptr_q] : '0;
        fifo_level = level_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_ltc2387_decimator.sv
// Directed testbench for ltc2387_decimator: pass-through latency, block means,
// extreme full-scale blocks, FIFO full/overflow, enable abort and ratio change,
// and asynchronous reset with a partly filled FIFO.
module tb_ltc2387_decimator;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [3:0]  dec_log2;
    logic [17:0] adc_data_in;
    logic        adc_valid_in;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr;

    int checks = 0;
    int errors = 0;

    ltc2387_decimator dut (
        .sys_clk_int  (clk),
        .reset_n_int  (reset_n),
        .enable       (enable),
        .dec_log2     (dec_log2),
        .adc_data_in  (adc_data_in),
        .adc_valid_in (adc_valid_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] s18(input int v);
        return {14'b0, v[17:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle valid strobe; returns at the negedge after the sampling edge.
    task automatic send(input int v);
        adc_data_in  = v[17:0];
        adc_valid_in = 1'b1;
        @(negedge clk);
        adc_valid_in = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, and let it pop (out_ready must be 1).
    task automatic expect_out(input string tag, input int v);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, {31'b0, out_valid}, 32'd1);
        chk(tag, {14'b0, out_data}, s18(v));
        $display("out %s: data=%0h", tag, out_data);
        @(negedge clk);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t1_vals [4];
        reset_n      = 1'b0;
        enable       = 1'b0;
        dec_log2     = 4'd0;
        adc_data_in  = '0;
        adc_valid_in = 1'b0;
        out_ready    = 1'b1;
        overflow_clr = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_data", {14'b0, out_data}, 32'd0);
        chk("rst level", {27'b0, fifo_level}, 32'd0);
        chk("rst overflow", {31'b0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: pass-through, result visible 2 cycles after its strobe
        t1_vals = '{5, -3, 32'h1FFFF, 32'h20000};
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            send(t1_vals[i]);
            chk("t1 not yet valid", {31'b0, out_valid}, 32'd0);
            tick();
            chk("t1 valid", {31'b0, out_valid}, 32'd1);
            chk("t1 data", {14'b0, out_data}, s18(t1_vals[i]));
            $display("t1 sample %0d: data=%0h", i, out_data);
            tick();
            chk("t1 popped", {31'b0, out_valid}, 32'd0);
        end

        // 2: block of 4, floor rounding
        go_idle();
        dec_log2 = 4'd2;
        enable = 1'b1;
        tick();
        send(1); send(2); send(3); send(5);
        expect_out("t2 mean 11/4", 2);
        send(-1); send(-1); send(-1); send(-2);
        expect_out("t2 mean -5/4", -2);

        // 3: maximum ratio with full-scale inputs
        go_idle();
        dec_log2 = 4'd8;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) send(32'h1FFFF);
        chk("t3 no early result", {27'b0, fifo_level}, 32'd0);
        send(32'h1FFFF);
        expect_out("t3 max positive", 131071);
        for (int i = 0; i < 256; i++) send(32'h20000);
        expect_out("t3 max negative", -131072);

        // 4: fill FIFO, overflow, then drain in order
        go_idle();
        dec_log2 = 4'd0;
        out_ready = 1'b0;
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) send(100 + i);
        tick();
        tick();
        chk("t4 level full", {27'b0, fifo_level}, 32'd16);
        chk("t4 overflow set", {31'b0, overflow}, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t4 drain valid", {31'b0, out_valid}, 32'd1);
            chk("t4 drain data", {14'b0, out_data}, s18(100 + i));
            $display("t4 drain %0d: data=%0h", i, out_data);
            tick();
        end
        chk("t4 empty", {27'b0, fifo_level}, 32'd0);
        chk("t4 overflow sticky", {31'b0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t4 overflow cleared", {31'b0, overflow}, 32'd0);

        // 5: abort partial block, then mid-block ratio change
        go_idle();
        dec_log2 = 4'd2;
        enable = 1'b1;
        tick();
        send(100); send(100); send(100);
        enable = 1'b0;
        tick();
        tick();
        tick();
        chk("t5 abort no push", {27'b0, fifo_level}, 32'd0);
        enable = 1'b1;
        tick();
        send(8); send(8); send(8); send(8);
        expect_out("t5 after re-enable", 8);
        send(4); send(4);
        dec_log2 = 4'd0;
        send(4);
        tick();
        chk("t5 ratio held mid-block", {27'b0, fifo_level}, 32'd0);
        send(4);
        expect_out("t5 old ratio block", 4);
        send(7);
        expect_out("t5 new ratio", 7);

        // 6: asynchronous reset with entries stored and a partial block
        go_idle();
        dec_log2 = 4'd0;
        out_ready = 1'b0;
        enable = 1'b1;
        tick();
        send(11); send(22);
        dec_log2 = 4'd2;
        send(33);
        send(1); send(1);
        tick();
        tick();
        chk("t6 level before reset", {27'b0, fifo_level}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 async out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6 async out_data", {14'b0, out_data}, 32'd0);
        chk("t6 async level", {27'b0, fifo_level}, 32'd0);
        chk("t6 async overflow", {31'b0, overflow}, 32'd0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t6 no stale data", {31'b0, out_valid}, 32'd0);
        send(10); send(10); send(10); send(10);
        expect_out("t6 fresh block", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
